// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment type, hex glyph table, scan-decoder FSM states
// and digit-select helpers.
package seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    // Active-low {g,f,e,d,c,b,a}, indexed by hex value
    localparam seg_t SEG_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // True when exactly one select line is pulled low
    function automatic logic sel_legal(input logic [7:0] an);
        logic [7:0] lo;
        lo = ~an;
        return (lo != 8'd0) && ((lo & (lo - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] sel_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!an[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan bus seen by the decoder: an/cn from the display driver, rebuilt word and status back.
interface seg_scan_decoder_if;
    import seg_pkg::*;

    logic [7:0]  an;
    seg_t        cn;
    logic [31:0] d;
    logic        valid;
    logic        err;
    logic        stale;

    modport master (
        output an, cn,
        input  d, valid, err, stale
    );

    modport slave (
        input  an, cn,
        output d, valid, err, stale
    );

endinterface

// File: rtl/seg7_to_hex.sv
// Combinational glyph decoder: active-low segment pattern to hex nibble plus legality flag.
module seg7_to_hex
    import seg_pkg::*;
(
    input  seg_t       cn,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (cn == SEG_GLYPH[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 32-bit hex word from a multiplexed 8-digit 7-seg scan bus.
// Optional FRAME_CONFIRM_EN: publish a frame only after two identical consecutive frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 2**20
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_decoder_if.slave bus
);

    localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] S_ONE = SW'(1);
    localparam logic [SW-1:0] S_MAX = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] T_ONE = TW'(1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

    logic [7:0]    an_r, an_p;
    seg_t          cn_r, cn_p;
    state_t        state, state_nx;
    logic [SW-1:0] scnt, scnt_nx;
    logic          load_cap;
    logic          legal, same;

    logic [7:0]    sel_q;
    seg_t          cap_cn;
    logic          do_cap;
    logic          glyph_ok;
    logic [3:0]    nib;
    logic [2:0]    cap_idx;
    logic [31:0]   shadow, shadow_w;
    logic [7:0]    mask, mask_w;
    logic          frame_done;
    logic          pub;

    logic [31:0]   d_q;
    logic          valid_q, err_q;
    logic [TW-1:0] tcnt;

    // One register stage plus a previous-sample copy for the stability compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r <= '1;
            an_p <= '1;
            cn_r <= '1;
            cn_p <= '1;
        end else begin
            an_r <= bus.an;
            cn_r <= bus.cn;
            an_p <= an_r;
            cn_p <= cn_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= '0;
        end else begin
            state <= state_nx;
            scnt  <= scnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        load_cap = 1'b0;
        legal    = sel_legal(an_r);
        same     = (an_r == an_p) && (cn_r == cn_p);
        case (state)
            IDLE: begin
                if (legal) begin
                    state_nx = SETTLE;
                    scnt_nx  = S_ONE;
                end
            end
            SETTLE: begin
                if (!legal) begin
                    state_nx = IDLE;
                    scnt_nx  = '0;
                end else begin
                    if (same) scnt_nx = (scnt == S_MAX) ? S_MAX : scnt + S_ONE;
                    else      scnt_nx = S_ONE;
                    if (scnt_nx == S_MAX) begin
                        state_nx = CAPTURE;
                        load_cap = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                state_nx = HOLD;
                scnt_nx  = '0;
            end
            HOLD: begin
                if (!legal || (an_r != sel_q)) begin
                    state_nx = IDLE;
                    scnt_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                scnt_nx  = '0;
            end
        endcase
    end

    // Freeze the settled select/segments so CAPTURE decodes exactly what was counted stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q  <= '1;
            cap_cn <= '1;
        end else if (load_cap) begin
            sel_q  <= an_r;
            cap_cn <= cn_r;
        end
    end

    seg7_to_hex u_seg7_to_hex (
        .cn     (cap_cn),
        .legal  (glyph_ok),
        .nibble (nib)
    );

    always_comb begin
        do_cap                       = (state == CAPTURE);
        cap_idx                      = sel_index(sel_q);
        shadow_w                     = shadow;
        shadow_w[{cap_idx, 2'b00} +: 4] = nib;
        mask_w                       = mask | (8'd1 << cap_idx);
        frame_done                   = do_cap && glyph_ok && (mask_w == 8'hFF);
    end

`ifdef FRAME_CONFIRM_EN
    logic [31:0] cand;
    logic        cand_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand   <= '0;
            cand_v <= 1'b0;
        end else if (frame_done) begin
            cand   <= shadow_w;
            cand_v <= 1'b1;
        end
    end

    assign pub = frame_done && cand_v && (shadow_w == cand);
`else
    assign pub = frame_done;
`endif

    // Frame completion is folded into the capture edge so d includes the nibble just written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            mask    <= '0;
            d_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tcnt    <= '0;
        end else begin
            valid_q <= pub;
            err_q   <= do_cap && !glyph_ok;
            if (do_cap && glyph_ok) begin
                shadow <= shadow_w;
                mask   <= frame_done ? '0 : mask_w;
            end
            if (pub) d_q <= shadow_w;
            if (pub)                tcnt <= '0;
            else if (tcnt != T_MAX) tcnt <= tcnt + T_ONE;
        end
    end

    assign bus.d     = d_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.stale = (tcnt == T_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: drives scan patterns, checks rebuilt words and status.
module tb_seg_scan_decoder;

    logic clk = 1'b0;
    logic rst;

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int nvalid   = 0;
    int nerr     = 0;
    logic [31:0] exp_q [$];

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Scoreboard side: every valid pops one expected word
    always @(negedge clk) begin
        if (!rst && bus.valid) begin
            logic [31:0] e;
            nvalid++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_valid d=%h expected no valid", bus.d);
            end else begin
                e = exp_q.pop_front();
                if (bus.d !== e) begin
                    failures++;
                    $display("FAIL sb_data d=%h expected %h", bus.d, e);
                end
            end
        end
        if (!rst && bus.err) nerr++;
    end

    task automatic drive(input logic [7:0] an, input logic [6:0] cn, input int n);
        bus.an = an;
        bus.cn = cn;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_digits(input logic [31:0] w, input int first, input int count, input int dwell);
        logic [7:0] sel;
        logic [3:0] nb;
        int dig;
        for (int k = 0; k < count; k++) begin
            dig = (first + k) % 8;
            sel = ~(8'd1 << dig);
            nb  = w[4*dig +: 4];
            drive(sel, glyph(nb), dwell);
        end
    endtask

    task automatic blank(input int n);
        drive(8'hFF, 7'h7F, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.an = 8'hFF;
        bus.cn = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Holds digit 7 until valid is seen or the budget runs out
    task automatic last_digit_until_valid(input logic [31:0] w, output bit seen);
        logic [3:0] nb;
        nb   = w[31:28];
        seen = 1'b0;
        bus.an = 8'h7F;
        bus.cn = glyph(nb);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid) seen = 1'b1;
        end
    endtask

    task automatic check_drained(input string name, input int v0, input int want);
        checks++;
        if ((nvalid - v0) !== want || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s valids=%0d expected %0d pending=%0d", name, nvalid - v0, want, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (bus.d !== 32'h0)  begin failures++; $display("FAIL reset_d d=%h expected 0", bus.d); end
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid valid=%b expected 0", bus.valid); end
        if (bus.err !== 1'b0)   begin failures++; $display("FAIL reset_err err=%b expected 0", bus.err); end
        if (bus.stale !== 1'b0) begin failures++; $display("FAIL reset_stale stale=%b expected 0", bus.stale); end
    endtask

    task automatic test_basic_scan();
        int v0;
        do_reset();
        v0 = nvalid;
        exp_q.push_back(32'h1234ABCD);
        scan_digits(32'h1234ABCD, 0, 8, 8);
        blank(12);
        check_drained("basic_scan", v0, 1);
    endtask

    task automatic test_start_mid();
        int v0;
        do_reset();
        v0 = nvalid;
        scan_digits(32'h0F1E2D3C, 5, 7, 8);
        checks++;
        if (nvalid !== v0) begin failures++; $display("FAIL start_mid_early valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'h0F1E2D3C);
        scan_digits(32'h0F1E2D3C, 4, 1, 8);
        blank(12);
        check_drained("start_mid", v0, 1);
    endtask

    task automatic test_short_dwell();
        int v0;
        do_reset();
        v0 = nvalid;
        scan_digits(32'h76543210, 0, 3, 8);
        scan_digits(32'h76543210, 3, 1, 3);
        scan_digits(32'h76543210, 4, 4, 8);
        blank(12);
        checks++;
        if (nvalid !== v0) begin failures++; $display("FAIL short_dwell_early valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'h76543210);
        scan_digits(32'h76543210, 0, 8, 8);
        blank(12);
        check_drained("short_dwell", v0, 1);
    endtask

    task automatic test_bad_glyph();
        int v0, e0;
        do_reset();
        v0 = nvalid;
        e0 = nerr;
        scan_digits(32'h89ABCDEF, 0, 2, 8);
        drive(8'hFB, 7'h7F, 8);
        scan_digits(32'h89ABCDEF, 3, 5, 8);
        blank(12);
        checks += 2;
        if (nerr - e0 !== 1)  begin failures++; $display("FAIL bad_glyph_err pulses=%0d expected 1", nerr - e0); end
        if (nvalid !== v0)    begin failures++; $display("FAIL bad_glyph_novalid valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'h89ABCDEF);
        scan_digits(32'h89ABCDEF, 2, 1, 8);
        blank(12);
        check_drained("bad_glyph_fill", v0, 1);
    endtask

    task automatic test_blank_select();
        int v0, e0;
        do_reset();
        v0 = nvalid;
        e0 = nerr;
        scan_digits(32'h5A5A0F0F, 0, 4, 8);
        drive(8'hFF, glyph(4'h3), 10);
        drive(8'h00, glyph(4'h3), 10);
        checks++;
        if (nvalid !== v0) begin failures++; $display("FAIL blank_sel_early valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'h5A5A0F0F);
        scan_digits(32'h5A5A0F0F, 4, 4, 8);
        blank(12);
        check_drained("blank_sel", v0, 1);
        checks++;
        if (nerr !== e0) begin failures++; $display("FAIL blank_sel_err pulses=%0d expected 0", nerr - e0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        scan_digits(32'h13579BDF, 0, 5, 8);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks += 2;
        if (bus.d !== 32'h0)    begin failures++; $display("FAIL reset_mid_d d=%h expected 0", bus.d); end
        if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_mid_valid valid=%b expected 0", bus.valid); end
        bus.an = 8'hFF;
        bus.cn = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v0 = nvalid;
        scan_digits(32'hDEADBEEF, 5, 7, 8);
        checks++;
        if (nvalid !== v0) begin failures++; $display("FAIL reset_mid_partial valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'hDEADBEEF);
        scan_digits(32'hDEADBEEF, 4, 1, 8);
        blank(12);
        check_drained("reset_mid_frame", v0, 1);
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        do_reset();
        checks++;
        if (bus.stale !== 1'b0) begin failures++; $display("FAIL timeout_init stale=%b expected 0", bus.stale); end
        exp_q.push_back(32'hC0FFEE42);
        scan_digits(32'hC0FFEE42, 0, 7, 8);
        last_digit_until_valid(32'hC0FFEE42, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL timeout_valid1 seen=0 expected 1"); end
        bus.an = 8'hFF;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.stale) begin n = i; break; end
        end
        checks++;
        if (n !== 64) begin failures++; $display("FAIL timeout_cycles stale_after=%0d expected 64", n); end
        exp_q.push_back(32'h600DF00D);
        scan_digits(32'h600DF00D, 0, 7, 8);
        checks++;
        if (bus.stale !== 1'b1) begin failures++; $display("FAIL timeout_held stale=%b expected 1", bus.stale); end
        last_digit_until_valid(32'h600DF00D, seen);
        checks += 2;
        if (!seen) begin failures++; $display("FAIL timeout_valid2 seen=0 expected 1"); end
        if (bus.stale !== 1'b0) begin failures++; $display("FAIL timeout_clear stale=%b expected 0", bus.stale); end
        blank(12);
    endtask

`ifdef FRAME_CONFIRM_EN
    task automatic test_confirm();
        int v0;
        do_reset();
        v0 = nvalid;
        scan_digits(32'h11111111, 0, 8, 8);
        blank(12);
        scan_digits(32'h22222222, 0, 8, 8);
        blank(12);
        checks++;
        if (nvalid !== v0) begin failures++; $display("FAIL confirm_early valids=%0d expected 0", nvalid - v0); end
        exp_q.push_back(32'h22222222);
        scan_digits(32'h22222222, 0, 8, 8);
        blank(12);
        check_drained("confirm", v0, 1);
    endtask
`endif

    initial begin
        rst    = 1'b1;
        bus.an = 8'hFF;
        bus.cn = 7'h7F;
        test_reset();
`ifdef FRAME_CONFIRM_EN
        test_confirm();
`else
        test_basic_scan();
        test_start_mid();
        test_short_dwell();
        test_bad_glyph();
        test_blank_select();
        test_reset_mid();
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
